spike_window_decoder: RTL
=========================

Name: spike_window_decoder

Overview:
- Downstream consumer of the LIF neuron. Samples the neuron's spike and membrane state outputs every clock.
- Decodes them over fixed-length observation windows into a rate code (spike count), a latency code (first-spike time) and the peak membrane value.
- Each window result is delivered through a valid/ready output port. Windows run back-to-back while enabled, with a one-deep result register.

Parameters:
- WIN_W, 8, width of window length and time index.
- CNT_W, 8, width of spike counter (saturating).
- STATE_W, 8, width of membrane state input (matches neuron state).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- en  in  1  run enable; low aborts current window
- win_len  in  WIN_W  window length in cycles; 0 treated as 1; sampled at window start
- spike  in  1  spike from neuron, sampled once per cycle
- state  in  STATE_W  neuron membrane potential, unsigned
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- spike_count  out  CNT_W  spikes in window
- first_time  out  WIN_W  cycle index (0-based) of first spike in window; all-ones if none
- no_spike  out  1  window had zero spikes
- peak_state  out  STATE_W  max state sampled in window
- saturated  out  1  spike_count clipped at max
- overrun  out  1  sticky: a completed window was dropped because the result register was full
- busy  out  1  high while in RUN

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Reset values: all outputs 0 except first_time = all-ones; FSM in IDLE; accumulators cleared.
- FSM states: IDLE, RUN.
  - IDLE to RUN on the first cycle en=1. Accumulators clear, t=0, and win_len is latched (0 becomes 1).
  - The first sample is taken on the first RUN cycle, not the enable cycle.
- RUN, every cycle:
  - count += spike, saturating at 2^CNT_W-1; sat flag set on any attempted increment at max.
  - First spike: if spike and no spike seen yet, first := t.
  - peak := max(peak, state).
  - t increments.
- Window end, on the cycle where t == win_len_latched-1 (that cycle's sample included):
  - Final values move to the result register; out_valid rises the next cycle (latency 1 after last sample).
  - Accumulators and t reset, win_len is re-latched, and the next window samples immediately on the following cycle, with no gap cycles.
- Result register: a transfer occurs on a cycle with out_valid && out_ready; outputs are held stable while out_valid && !out_ready.
- Window end with the register full and no transfer that cycle: the new result is discarded, the old one is kept, and overrun sets.
- Window end in the same cycle as a transfer: the new result loads and out_valid stays 1. This is not an overrun.
- en low while in RUN: partial window discarded and FSM goes to IDLE next cycle. A pending result stays valid until taken.
- overrun clears only on rst or on an IDLE-to-RUN transition.
- no_spike = (count==0) in the result. first_time = all-ones when no_spike.
- win_len changes mid-window are ignored until the next window start.

Decomposition:
- Package lif_pkg holds:
  - the WIN_W/CNT_W/STATE_W defaults;
  - an enum for the FSM states (IDLE, RUN);
  - a packed struct win_result_t {count, first, no_spike, peak, sat}.
- One sub-module, spike_window_acc: the per-window accumulators (count, first, peak, sat, t) with clear and sample inputs and a done output.
- The top holds the FSM, win_len latch, result register and overrun logic.

Test Plan:
- Basic rate and latency: rst then en=1, win_len=4, spikes at t=1,3, state 5,9,2,7 -> one result: count=2, first_time=1, peak=9, no_spike=0; out_valid 1 cycle after t=3.
- Empty window: win_len=3, no spikes, state=0 -> count=0, no_spike=1, first_time=8'hFF, peak=0.
- Saturation: CNT_W=8, win_len=0 (treated as 1) repeatedly vs. win_len=255 with spike constant 1 and a CNT_W=4 build -> count=15, saturated=1.
- Backpressure: win_len=2, out_ready=0 for 6 cycles -> first result held unchanged, overrun=1, later windows dropped. Then out_ready=1 in the same cycle as a window end -> new result loaded, overrun still 1, no gap in out_valid.
- Abort: en dropped at t=2 of a win_len=8 window -> no result for that window, busy=0 next cycle. Re-enable -> overrun clear, fresh window from t=0.
- Async reset mid-window with out_valid=1: assert rst between clock edges -> outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared definitions for the spike window decoder.
// Holds the default widths, the decoder FSM state encoding and the packed
// window-result record. The result record is sized for the default widths;
// decoder instances must use widths no larger than these defaults. Narrower
// fields are stored zero-extended.
package lif_pkg;

    localparam int WIN_W_DEF   = 8;
    localparam int CNT_W_DEF   = 8;
    localparam int STATE_W_DEF = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    typedef struct packed {
        logic [CNT_W_DEF-1:0]   count;
        logic [WIN_W_DEF-1:0]   first;
        logic                   no_spike;
        logic [STATE_W_DEF-1:0] peak;
        logic                   sat;
    } win_result_t;

endpackage

// File: rtl/spike_window_acc.sv
// Per-window accumulators: saturating spike count, first-spike time, peak
// membrane state, saturation flag and window time index.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   clear        restart the window (priority over sample)
//   sample       take this cycle's spike/state into the window
//   spike, state neuron outputs
//   last_idx     time index of the final sample of the window
//   count_next, first_next, peak_next, sat_next
//                window values including this cycle's sample
//   done         this cycle's sample completes the window
module spike_window_acc
    import lif_pkg::*;
#(
    parameter int WIN_W   = WIN_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int STATE_W = STATE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               sample,
    input  logic               spike,
    input  logic [STATE_W-1:0] state,
    input  logic [WIN_W-1:0]   last_idx,
    output logic [CNT_W-1:0]   count_next,
    output logic [WIN_W-1:0]   first_next,
    output logic [STATE_W-1:0] peak_next,
    output logic               sat_next,
    output logic               done
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]   count_reg;
    logic [WIN_W-1:0]   first_reg;
    logic [STATE_W-1:0] peak_reg;
    logic               sat_reg;
    logic [WIN_W-1:0]   t_reg;

    // A zero count means no spike has been seen yet in this window, since
    // the counter saturates instead of wrapping.
    always_comb begin
        count_next = count_reg;
        first_next = first_reg;
        peak_next  = peak_reg;
        sat_next   = sat_reg;
        if (spike) begin
            if (count_reg == CNT_MAX) begin
                sat_next = 1'b1;
            end else begin
                count_next = count_reg + 1'b1;
            end
            if (count_reg == '0) begin
                first_next = t_reg;
            end
        end
        if (state > peak_reg) begin
            peak_next = state;
        end
    end

    assign done = sample && (t_reg == last_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            first_reg <= '1;
            peak_reg  <= '0;
            sat_reg   <= 1'b0;
            t_reg     <= '0;
        end else if (clear) begin
            count_reg <= '0;
            first_reg <= '1;
            peak_reg  <= '0;
            sat_reg   <= 1'b0;
            t_reg     <= '0;
        end else if (sample) begin
            count_reg <= count_next;
            first_reg <= first_next;
            peak_reg  <= peak_next;
            sat_reg   <= sat_next;
            t_reg     <= t_reg + 1'b1;
        end
    end

endmodule

// File: rtl/spike_window_decoder.sv
// Decodes LIF neuron spike/state streams over back-to-back fixed-length
// windows into rate (count), latency (first spike) and peak-state codes,
// delivered through a one-deep valid/ready result register.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   en               run enable; low aborts the current window
//   win_len          window length (0 means 1), latched at window start
//   spike, state     neuron outputs sampled each RUN cycle
//   out_valid/ready  result handshake
//   spike_count, first_time, no_spike, peak_state, saturated
//                    fields of the held window result
//   overrun          sticky: a finished window was dropped (register full)
//   busy             FSM is in RUN
module spike_window_decoder
    import lif_pkg::*;
#(
    parameter int WIN_W   = WIN_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int STATE_W = STATE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [WIN_W-1:0]   win_len,
    input  logic               spike,
    input  logic [STATE_W-1:0] state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   spike_count,
    output logic [WIN_W-1:0]   first_time,
    output logic               no_spike,
    output logic [STATE_W-1:0] peak_state,
    output logic               saturated,
    output logic               overrun,
    output logic               busy
);

    fsm_state_t       state_reg;
    logic [WIN_W-1:0] last_idx_reg;
    logic [WIN_W-1:0] last_idx_new;
    win_result_t      res_reg;
    logic             valid_reg;
    logic             overrun_reg;

    logic               start;
    logic               sample;
    logic               done;
    logic               xfer;
    logic [CNT_W-1:0]   count_next;
    logic [WIN_W-1:0]   first_next;
    logic [STATE_W-1:0] peak_next;
    logic               sat_next;

    assign start  = (state_reg == IDLE) && en;
    assign sample = (state_reg == RUN) && en;
    assign xfer   = valid_reg && out_ready;

    // A zero length behaves as a single-cycle window.
    assign last_idx_new = (win_len == '0) ? '0 : win_len - 1'b1;

    spike_window_acc #(
        .WIN_W   (WIN_W),
        .CNT_W   (CNT_W),
        .STATE_W (STATE_W)
    ) u_acc (
        .clk        (clk),
        .rst        (rst),
        .clear      (start || done),
        .sample     (sample),
        .spike      (spike),
        .state      (state),
        .last_idx   (last_idx_reg),
        .count_next (count_next),
        .first_next (first_next),
        .peak_next  (peak_next),
        .sat_next   (sat_next),
        .done       (done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            last_idx_reg <= '0;
            res_reg      <= '{count: '0, first: '1, no_spike: 1'b0, peak: '0, sat: 1'b0};
            valid_reg    <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (en) begin
                        state_reg    <= RUN;
                        last_idx_reg <= last_idx_new;
                        overrun_reg  <= 1'b0;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state_reg <= IDLE;
                    end else if (done) begin
                        last_idx_reg <= last_idx_new;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // A window ending while the held result is being taken reloads
            // the register without a gap in out_valid.
            if (done) begin
                if (!valid_reg || xfer) begin
                    res_reg.count    <= CNT_W_DEF'(count_next);
                    res_reg.first    <= (count_next == '0) ? '1 : WIN_W_DEF'(first_next);
                    res_reg.no_spike <= (count_next == '0);
                    res_reg.peak     <= STATE_W_DEF'(peak_next);
                    res_reg.sat      <= sat_next;
                    valid_reg        <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (xfer) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid   = valid_reg;
    assign spike_count = res_reg.count[CNT_W-1:0];
    assign first_time  = res_reg.first[WIN_W-1:0];
    assign no_spike    = res_reg.no_spike;
    assign peak_state  = res_reg.peak[STATE_W-1:0];
    assign saturated   = res_reg.sat;
    assign overrun     = overrun_reg;
    assign busy        = (state_reg == RUN);

endmodule
